// File: rtl/crc_frame_pkg.sv
// Shared types and the bit-serial CRC-8 step used by the egress CRC sequencer.
package crc_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    APPEND  = 2'd2,
    DROP    = 2'd3
  } state_e;

  localparam logic [7:0] CRC_SEED_DEFAULT = 8'hE7;
  localparam logic [7:0] CRC_POLY_DEFAULT = 8'hAB;

  // Data bits enter LSB first at the bottom of the register; no reflection, no final XOR.
  function automatic logic [7:0] crc8_step(input logic [7:0] c,
                                           input logic [7:0] d,
                                           input logic [7:0] poly = CRC_POLY_DEFAULT);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[6:0], d[i]} ^ (r[7] ? poly : 8'h00);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_frame_ctrl_if.sv
// Byte stream with packet delimiters; master drives data, slave drives ready.
interface crc_frame_ctrl_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       sop;
  logic       eop;

  modport master (output valid, output data, output sop, output eop, input ready);
  modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/crc8_next.sv
// One-byte combinational CRC-8 advance with a configurable polynomial.
module crc8_next
  import crc_frame_pkg::*;
#(
  parameter logic [7:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  assign crc_out = crc8_step(crc_in, data_in, POLY);

endmodule

// File: rtl/crc_frame_ctrl.sv
// Egress CRC sequencer: forwards payload bytes, appends a CRC-8 byte per packet,
// and polices SOP/EOP framing and maximum payload length.
module crc_frame_ctrl
  import crc_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 255,
  parameter int unsigned LEN_W    = 8,
  parameter logic [7:0]  CRC_SEED = CRC_SEED_DEFAULT,
  parameter logic [7:0]  CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  crc_frame_ctrl_if.slave   in_if,
  crc_frame_ctrl_if.master  out_if,
  output logic              err_framing,
  output logic              err_oversize,
  output logic [15:0]       pkt_count
);

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_W     = LEN_W'(1);
  localparam bit               SOP_FULL  = (ONE_W == MAX_LEN_W);

  state_e           state_q, state_d;
  logic [7:0]       crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc;
  logic             poison_q, poison_d;
  logic             oversize_q, oversize_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic             err_framing_q, err_framing_d;
  logic             err_oversize_q, err_oversize_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic             slot_free;
  logic             in_ready;
  logic             accept;
  logic             start_pkt;
  logic             out_fire;
  logic [7:0]       crc_base;
  logic [7:0]       crc_step;

  assign slot_free = !out_valid_q || out_if.ready;
  assign accept    = in_if.valid && in_ready;
  assign out_fire  = out_valid_q && out_if.ready && out_eop_q;
  assign len_inc   = len_q + ONE_W;

  // Only PAYLOAD continues a running CRC; every other state can only start a packet.
  assign crc_base = (state_q == PAYLOAD) ? crc_q : CRC_SEED;

  crc8_next #(
    .POLY (CRC_POLY)
  ) u_crc8_next (
    .crc_in  (crc_base),
    .data_in (in_if.data),
    .crc_out (crc_step)
  );

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = slot_free;
      PAYLOAD: in_ready = slot_free && !in_if.sop;
      APPEND:  in_ready = 1'b0;
      // A SOP in DROP starts a packet immediately, so it must wait for the output slot.
      DROP:    in_ready = !in_if.sop || slot_free;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    len_d          = len_q;
    poison_d       = poison_q;
    oversize_d     = oversize_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_sop_d      = out_sop_q;
    out_eop_d      = out_eop_q;
    err_framing_d  = 1'b0;
    err_oversize_d = 1'b0;
    pkt_count_d    = pkt_count_q + 16'(out_fire);
    start_pkt      = 1'b0;

    if (slot_free) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_if.sop) begin
            start_pkt = 1'b1;
          end else begin
            err_framing_d = 1'b1;
          end
        end
      end

      PAYLOAD: begin
        if (in_if.valid && in_if.sop) begin
          err_framing_d = 1'b1;
          poison_d      = 1'b1;
          state_d       = APPEND;
        end else if (accept) begin
          crc_d       = crc_step;
          len_d       = len_inc;
          out_valid_d = 1'b1;
          out_data_d  = in_if.data;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          if (in_if.eop) begin
            state_d = APPEND;
          end else if (len_inc == MAX_LEN_W) begin
            err_oversize_d = 1'b1;
            poison_d       = 1'b1;
            oversize_d     = 1'b1;
            state_d        = APPEND;
          end
        end
      end

      APPEND: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = poison_q ? ~crc_q : crc_q;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          state_d     = oversize_q ? DROP : IDLE;
        end
      end

      DROP: begin
        if (accept) begin
          if (in_if.sop) begin
            start_pkt = 1'b1;
          end else if (in_if.eop) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (start_pkt) begin
      crc_d       = crc_step;
      len_d       = ONE_W;
      poison_d    = 1'b0;
      oversize_d  = 1'b0;
      out_valid_d = 1'b1;
      out_data_d  = in_if.data;
      out_sop_d   = 1'b1;
      out_eop_d   = 1'b0;
      if (in_if.eop) begin
        state_d = APPEND;
      end else if (SOP_FULL) begin
        err_oversize_d = 1'b1;
        poison_d       = 1'b1;
        oversize_d     = 1'b1;
        state_d        = APPEND;
      end else begin
        state_d = PAYLOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      crc_q          <= CRC_SEED;
      len_q          <= '0;
      poison_q       <= 1'b0;
      oversize_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= 8'h00;
      out_sop_q      <= 1'b0;
      out_eop_q      <= 1'b0;
      err_framing_q  <= 1'b0;
      err_oversize_q <= 1'b0;
      pkt_count_q    <= 16'h0000;
    end else begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      len_q          <= len_d;
      poison_q       <= poison_d;
      oversize_q     <= oversize_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_sop_q      <= out_sop_d;
      out_eop_q      <= out_eop_d;
      err_framing_q  <= err_framing_d;
      err_oversize_q <= err_oversize_d;
      pkt_count_q    <= pkt_count_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign out_if.sop   = out_sop_q;
  assign out_if.eop   = out_eop_q;
  assign err_framing  = err_framing_q;
  assign err_oversize = err_oversize_q;
  assign pkt_count    = pkt_count_q;

endmodule
